multicycle_controller: RTL

Parametrised multicycle successor to the single-cycle main decoder: a state machine that sequences fetch, decode, execute, memory and writeback for RV32I (lw/sw, R/I-type ALU, all six branches, jal, jalr, lui, auipc). It sits between the datapath's shared instruction/data memory port and the register/ALU control. It also adds a ready/request memory handshake with a wait-state watchdog, illegal-opcode trapping and a sticky fault flag.

---
 rtl/multicycle_controller_if.sv | 10 +
 rtl/multicycle_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake between the multicycle controller and memory.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic AdrSrc;
  logic MemWrite;

  modport master (output mem_req, output AdrSrc, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input AdrSrc, input MemWrite, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM with memory wait-state watchdog and illegal-op trapping.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module multicycle_controller #(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned WAIT_W    = 8
`ifdef MC_INSTRET_EN
  ,
  parameter int unsigned INSTRET_W = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master mem,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    Zero,
  input  logic                    Lt,
  input  logic                    Ltu,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    RegWrite,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              ResultSrc,
  output logic [2:0]              ImmSrc,
  output logic [3:0]              state_o,
  output logic                    fault
`ifdef MC_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0]    instret
`endif
);

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalrAdr  = 4'd11,
    StUpper    = 4'd12,
    StTrap     = 4'd15
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fault_q;
  logic                mem_state, wd_expire, taken, bad_branch;
  logic                mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  assign wd_expire = (MAX_WAIT > 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    taken      = 1'b0;
    bad_branch = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = !Ltu;
      default: bad_branch = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OpSw:          ImmSrc = 3'b001;
      OpBr:          ImmSrc = 3'b010;
      OpJal:         ImmSrc = 3'b011;
      OpLui, OpAuipc: ImmSrc = 3'b100;
      default:       ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_state   = 1'b0;
    mem_req_c   = 1'b0;
    mem.AdrSrc  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    case (state_q)
      StFetch: begin
        mem_state = 1'b1;
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw:     state_d = StMemAdr;
          OpR:            state_d = StExecR;
          OpI:            state_d = StExecI;
          OpBr:           state_d = StBranch;
          OpJal:          state_d = StJal;
          OpJalr:         state_d = StJalrAdr;
          OpLui, OpAuipc: state_d = StUpper;
          default:        state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_state  = 1'b1;
        mem_req_c  = 1'b1;
        mem.AdrSrc = 1'b1;
        if (mem.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        mem_state   = 1'b1;
        mem_req_c   = 1'b1;
        mem.AdrSrc  = 1'b1;
        mem_write_c = 1'b1;
        if (mem.mem_ready) state_d = StFetch;
      end
      StExecR, StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == StExecI) ? 2'b01 : 2'b00;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_c = taken;
        state_d    = bad_branch ? StTrap : StFetch;
      end
      StJalrAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = StJal;
      end
      StJal: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = StAluWb;
      end
      StUpper: begin
        reg_write_c = 1'b1;
        ResultSrc   = (op == OpLui) ? 2'b11 : 2'b00;
        state_d     = StFetch;
      end
      default: state_d = StTrap;
    endcase
    // A completing access always wins over the watchdog.
    if (mem_state && !mem.mem_ready && wd_expire) state_d = StTrap;
  end

  // Entry into a memory state always follows a cleared count, so clearing off-wait suffices.
  assign wait_d = (mem_state && !mem.mem_ready) ? wait_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_q | (state_d == StTrap);
    end
  end

`ifdef MC_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  assign retire = (state_d == StFetch) &&
                  (state_q inside {StMemWb, StMemWrite, StAluWb, StBranch, StUpper});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else if (retire) instret_q <= instret_q + 1'b1;
  end

  assign instret = instret_q;
`endif

  assign mem.mem_req  = mem_req_c & reset_n;
  assign mem.MemWrite = mem_write_c & reset_n;
  assign IRWrite      = ir_write_c & reset_n;
  assign PCWrite      = pc_write_c & reset_n;
  assign RegWrite     = reg_write_c & reset_n;
  assign state_o      = state_q;
  assign fault        = fault_q;

endmodule
